// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM output-stationary MAC grid: operand skew, accumulator clear, drain, done.
// Optional STALL_CNT_EN adds o_stall_cnt, a saturating count of FEED cycles without a valid operand.
module systolic_seq_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ARRAY_DIM  = 4,
   parameter int unsigned KLEN_W     = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic [KLEN_W-1:0]                 i_k_len,
   input  logic                              i_abort,
   input  logic                              i_op_valid,
   output logic                              o_op_ready,
   input  logic [ARRAY_DIM*DATA_WIDTH-1:0]   i_a_vec,
   input  logic [ARRAY_DIM*DATA_WIDTH-1:0]   i_b_vec,
   output logic [ARRAY_DIM*DATA_WIDTH-1:0]   o_a_edge,
   output logic [ARRAY_DIM*DATA_WIDTH-1:0]   o_b_edge,
   output logic                              o_mac_clr,
   output logic                              o_busy,
`ifdef STALL_CNT_EN
   output logic [31:0]                       o_stall_cnt,
`endif
   output logic                              o_done
);

   localparam int unsigned DRAIN_LEN = 2 * ARRAY_DIM;
   localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [KLEN_W-1:0]   r_k_len;
   logic [KLEN_W-1:0]   r_beat_cnt;
   logic [DRAIN_W-1:0]  r_drain_cnt;
   logic                r_op_ready;
   logic                r_mac_clr;
   logic                r_busy;
   logic                r_done;
   logic                w_op_ready_nxt;
   logic                w_mac_clr_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_beat;
   logic                w_last_beat;

   assign w_beat      = (r_state == S_FEED) && i_op_valid && r_op_ready;
   assign w_last_beat = w_beat && (r_beat_cnt == (r_k_len - KLEN_W'(1)));

   // Next state and next registered outputs; abort wins over every other busy transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_CLEAR;
         S_CLEAR: begin
            if (i_abort)               w_state_nxt = S_FLUSH;
            else if (r_k_len == '0)    w_state_nxt = S_DRAIN;
            else                       w_state_nxt = S_FEED;
         end
         S_FEED: begin
            if (i_abort)               w_state_nxt = S_FLUSH;
            else if (w_last_beat)      w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (i_abort)               w_state_nxt = S_FLUSH;
            else if (r_drain_cnt == DRAIN_W'(DRAIN_LEN - 1))
                                       w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_FLUSH: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_op_ready_nxt = (w_state_nxt == S_FEED);
      w_mac_clr_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FLUSH);
      w_busy_nxt     = (w_state_nxt != S_IDLE);
      w_done_nxt     = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_k_len     <= '0;
         r_beat_cnt  <= '0;
         r_drain_cnt <= '0;
         r_op_ready  <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op_ready <= w_op_ready_nxt;
         r_mac_clr  <= w_mac_clr_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         if ((r_state == S_IDLE) && i_start) r_k_len <= i_k_len;
         if (w_state_nxt == S_CLEAR)         r_beat_cnt <= '0;
         else if (w_beat)                    r_beat_cnt <= r_beat_cnt + KLEN_W'(1);
         if (r_state == S_DRAIN)             r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
         else                                r_drain_cnt <= '0;
      end
   end

   assign o_op_ready = r_op_ready;
   assign o_mac_clr  = r_mac_clr;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

   // Lane i is an (i+1)-deep shift line; non-beat cycles shift in zeros so bubbles stay aligned.
   for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
      logic [gi:0][DATA_WIDTH-1:0] r_a_sr;
      logic [gi:0][DATA_WIDTH-1:0] r_b_sr;
      logic [DATA_WIDTH-1:0]       w_a_in;
      logic [DATA_WIDTH-1:0]       w_b_in;

      assign w_a_in = w_beat ? i_a_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign w_b_in = w_beat ? i_b_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
         end else if (w_mac_clr_nxt) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
         end else begin
            r_a_sr <= ((gi + 1) * DATA_WIDTH)'({r_a_sr, w_a_in});
            r_b_sr <= ((gi + 1) * DATA_WIDTH)'({r_b_sr, w_b_in});
         end
      end

      assign o_a_edge[gi*DATA_WIDTH +: DATA_WIDTH] = r_a_sr[gi];
      assign o_b_edge[gi*DATA_WIDTH +: DATA_WIDTH] = r_b_sr[gi];
   end

`ifdef STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_stall_cnt <= '0;
      else if (w_state_nxt == S_CLEAR)
         r_stall_cnt <= '0;
      else if ((r_state == S_FEED) && !i_op_valid && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized job-level bench for systolic_seq_ctrl: cycle-timeline expectations, skew history and a MAC-grid model.
module tb_systolic_seq_ctrl;

   localparam int DW   = 32;
   localparam int DIM  = 4;
   localparam int KW   = 8;
   localparam int AW   = DW * DIM;
   localparam int HMAX = 16384;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          op_valid = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic [AW-1:0] a_vec = '0;
   logic [AW-1:0] b_vec = '0;
   logic          op_ready;
   logic [AW-1:0] a_edge;
   logic [AW-1:0] b_edge;
   logic          mac_clr;
   logic          busy;
   logic          done;
`ifdef STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   systolic_seq_ctrl #(.DATA_WIDTH(DW), .ARRAY_DIM(DIM), .KLEN_W(KW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_k_len    (k_len),
      .i_abort    (abort),
      .i_op_valid (op_valid),
      .o_op_ready (op_ready),
      .i_a_vec    (a_vec),
      .i_b_vec    (b_vec),
      .o_a_edge   (a_edge),
      .o_b_edge   (b_edge),
      .o_mac_clr  (mac_clr),
      .o_busy     (busy),
`ifdef STALL_CNT_EN
      .o_stall_cnt(stall_cnt),
`endif
      .o_done     (done)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            stalls   = 0;
   logic [AW-1:0] hist_a [HMAX];
   logic [AW-1:0] hist_b [HMAX];
   logic [DW-1:0] exp_c  [DIM][DIM];

   // Downstream output-stationary grid: A flows right, B flows down, each PE accumulates.
   logic [DW-1:0] g_acc [DIM][DIM];
   logic [DW-1:0] g_a   [DIM][DIM];
   logic [DW-1:0] g_b   [DIM][DIM];

   always @(posedge clk) begin
      logic [DW-1:0] ai;
      logic [DW-1:0] bi;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            ai = (c == 0) ? a_edge[r*DW +: DW] : g_a[r][c-1];
            bi = (r == 0) ? b_edge[c*DW +: DW] : g_b[r-1][c];
            g_a[r][c]   <= ai;
            g_b[r][c]   <= bi;
            g_acc[r][c] <= mac_clr ? '0 : g_acc[r][c] + ai * bi;
         end
      end
   end

   task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= HMAX) begin
         n_fail++;
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HMAX);
         $fatal(1, "cycle budget exhausted");
      end
   endtask

   function automatic logic [AW-1:0] rvec();
      logic [AW-1:0] v;
      for (int i = 0; i < DIM; i++) v[i*DW +: DW] = $urandom;
      return v;
   endfunction

   // mode 0 random, 1 identity column per beat, 2 all threes, 3 lane i carries i+1
   function automatic logic [AW-1:0] mk_vec(input int mode, input int beat);
      logic [AW-1:0] v;
      v = rvec();
      for (int i = 0; i < DIM; i++) begin
         case (mode)
            1: v[i*DW +: DW] = (i == beat) ? 32'd1 : 32'd0;
            2: v[i*DW +: DW] = 32'd3;
            3: v[i*DW +: DW] = DW'(i + 1);
            default: ;
         endcase
      end
      return v;
   endfunction

   task automatic clear_hist(input int upto);
      for (int k = 0; k <= upto && k < HMAX; k++) begin
         hist_a[k] = '0;
         hist_b[k] = '0;
      end
   endtask

   task automatic put(input logic st, input logic ab, input logic vld,
                      input logic [AW-1:0] av, input logic [AW-1:0] bv, input logic is_beat);
      start    = st;
      abort    = ab;
      op_valid = vld;
      a_vec    = av;
      b_vec    = bv;
      hist_a[cyc] = is_beat ? av : '0;
      hist_b[cyc] = is_beat ? bv : '0;
   endtask

   task automatic put_junk(input logic st, input logic ab);
      k_len = KW'($urandom);
      put(st, ab, 1'($urandom), rvec(), rvec(), 1'b0);
   endtask

   // Lane i of the edge shows the beat taken i+1 cycles earlier, else zero.
   task automatic check_outputs(input logic e_busy, input logic e_ready, input logic e_clr, input logic e_done);
      logic [AW-1:0] ea;
      logic [AW-1:0] eb;
      ea = '0;
      eb = '0;
      for (int i = 0; i < DIM; i++) begin
         int idx;
         idx = cyc - i - 1;
         if (idx >= 0) begin
            ea[i*DW +: DW] = hist_a[idx][i*DW +: DW];
            eb[i*DW +: DW] = hist_b[idx][i*DW +: DW];
         end
      end
      chk("busy",     AW'(busy),     AW'(e_busy));
      chk("op_ready", AW'(op_ready), AW'(e_ready));
      chk("mac_clr",  AW'(mac_clr),  AW'(e_clr));
      chk("done",     AW'(done),     AW'(e_done));
      chk("a_edge",   a_edge, ea);
      chk("b_edge",   b_edge, eb);
   endtask

   task automatic idle_gap();
      repeat (2 * DIM + 2) begin
         put_junk(1'b0, 1'($urandom));
         tick();
         check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic finish_abort();
      clear_hist(cyc - 1);
      check_outputs(1'b1, 1'b0, 1'b1, 1'b0);
      put_junk(1'b0, 1'b0);
      tick();
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      idle_gap();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      clear_hist(cyc);
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STALL_CNT_EN
      chk("stall_cnt_rst", AW'(stall_cnt), AW'(0));
`endif
      repeat (2) begin
         put_junk(1'($urandom), 1'($urandom));
         tick();
         check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      end
      put_junk(1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      idle_gap();
   endtask

   // ab_phase: 0 none, 1 abort in CLEAR, 2 abort at FEED cycle ab_idx, 3 abort at DRAIN cycle ab_idx
   task automatic run_job(input int klen, input int pvalid, input int stall_mask, input int mode,
                          input int ab_phase, input int ab_idx, input logic rst_drain);
      int            beats;
      int            fcyc;
      logic          vld;
      logic          ab;
      logic          is_beat;
      logic [AW-1:0] av;
      logic [AW-1:0] bv;

      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      stalls = 0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) exp_c[r][c] = '0;

      put(1'b1, 1'($urandom), 1'($urandom), rvec(), rvec(), 1'b0);
      k_len = KW'(klen);
      tick();

      check_outputs(1'b1, 1'b0, 1'b1, 1'b0);
      put_junk(1'($urandom), (ab_phase == 1) ? 1'b1 : 1'b0);
      tick();
      if (ab_phase == 1) begin
         finish_abort();
         return;
      end

      beats = 0;
      fcyc  = 0;
      while (beats < klen) begin
         check_outputs(1'b1, 1'b1, 1'b0, 1'b0);
         vld = !(fcyc < 32 && stall_mask[fcyc]) && (int'($urandom_range(0, 99)) < pvalid);
         ab  = (ab_phase == 2) && (fcyc == ab_idx);
         av  = mk_vec(mode, beats);
         bv  = mk_vec(mode, beats);
         is_beat = vld && !ab;
         k_len = KW'($urandom);
         put(1'($urandom), ab, vld, av, bv, is_beat);
         if (!vld) stalls++;
         if (is_beat) begin
            for (int r = 0; r < DIM; r++)
               for (int c = 0; c < DIM; c++)
                  exp_c[r][c] = exp_c[r][c] + av[r*DW +: DW] * bv[c*DW +: DW];
            beats++;
         end
         tick();
         fcyc++;
         if (ab) begin
            finish_abort();
            return;
         end
      end

      for (int d = 0; d < 2 * DIM; d++) begin
         check_outputs(1'b1, 1'b0, 1'b0, 1'b0);
         if (rst_drain && d == 3) begin
            reset_pulse();
            return;
         end
         ab = (ab_phase == 3) && (d == ab_idx);
         put_junk(1'($urandom), ab);
         tick();
         if (ab) begin
            finish_abort();
            return;
         end
      end

      check_outputs(1'b1, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            chk("c_grid", AW'(g_acc[r][c]), AW'(exp_c[r][c]));
`ifdef STALL_CNT_EN
      chk("stall_cnt", AW'(stall_cnt), AW'(stalls));
`endif
      put_junk(1'b1, 1'($urandom));
      tick();
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
      idle_gap();
   endtask

   initial begin
      int klen;
      int ph;
      int idx;

      clear_hist(HMAX - 1);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            g_acc[r][c] = '0;
            g_a[r][c]   = '0;
            g_b[r][c]   = '0;
         end

      repeat (2) begin
         put_junk(1'b0, 1'b0);
         tick();
      end
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STALL_CNT_EN
      chk("stall_cnt_rst", AW'(stall_cnt), AW'(0));
`endif
      rst_n = 1'b1;
      idle_gap();

      run_job(4,   100, 0,      1, 0, 0, 1'b0);
      run_job(1,   100, 0,      3, 0, 0, 1'b0);
      run_job(4,   100, 'b0110, 0, 0, 0, 1'b0);
      run_job(4,   100, 0,      0, 2, 1, 1'b0);
      run_job(1,   100, 0,      2, 0, 0, 1'b0);
      run_job(0,   100, 0,      0, 0, 0, 1'b0);
      run_job(3,   100, 0,      0, 0, 0, 1'b1);
      run_job(2,   100, 0,      0, 0, 0, 1'b0);
      run_job(5,   100, 0,      0, 1, 0, 1'b0);
      run_job(5,   80,  0,      0, 3, 2, 1'b0);
      run_job(5,   80,  0,      0, 3, 2 * DIM - 1, 1'b0);
      run_job(255, 100, 0,      0, 0, 0, 1'b0);

      for (int j = 0; j < 30; j++) begin
         klen = int'($urandom_range(0, 12));
         ph   = (int'($urandom_range(0, 5)) < 4) ? 0 : int'($urandom_range(1, 3));
         if (ph == 2 && klen == 0) ph = 0;
         idx  = (ph == 2) ? int'($urandom_range(0, klen)) :
                (ph == 3) ? int'($urandom_range(0, 2 * DIM - 1)) : 0;
         run_job(klen, int'($urandom_range(40, 100)), 0, 0, ph, idx,
                 (int'($urandom_range(0, 9)) == 0) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
